// File: rtl/rv32_bus_pkg.sv
// Shared types and constants for the RV32 instruction/data bus arbiter.
//   state_t  : arbiter FSM states (IDLE, BUSY, RESP)
//   grant_t  : which requester owns the shared bus (INS, DAT)
//   TIMEOUT_CYCLES_DEFAULT : default BUSY-cycle budget before abandoning an access
//   TIMER_W  : width of the watchdog counter (limit range 1..65535)
package rv32_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    INS = 1'b0,
    DAT = 1'b1
  } grant_t;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;
  localparam int unsigned TIMER_W                = 16;

endpackage

// File: rtl/rv32_bus_watchdog.sv
// Watchdog counter for a single outstanding bus access.
//   i_clk     : clock
//   i_rst     : synchronous active-high reset
//   i_clear   : zero the count (held while no access is in flight)
//   i_enable  : count one wait cycle
//   i_limit   : count value at which the access is considered abandoned
//   o_expired : count has reached i_limit
module rv32_bus_watchdog
  import rv32_bus_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [TIMER_W-1:0] i_limit,
  output logic               o_expired
);

  logic [TIMER_W-1:0] count;

  // Holds at the limit so the counter can never wrap back below it.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      count <= '0;
    end else if (i_enable && !o_expired) begin
      count <= count + 1'b1;
    end
  end

  assign o_expired = (count == i_limit);

endmodule

// File: rtl/rv32_bus_arbiter.sv
// Two-master arbiter (instruction fetch, load/store) onto one memory bus.
// One access in flight at a time: IDLE grants, BUSY drives the bus until the
// slave answers or the watchdog expires, RESP pulses the winner's ready.
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   i_ins_valid/addr                   : fetch request
//   o_ins_ready/rdata/error            : fetch completion (data/error 0 unless ready)
//   i_dat_valid/addr/we/wdata/wstrb    : load/store request
//   o_dat_ready/rdata/error            : load/store completion
//   o_mem_valid/addr/we/wdata/wstrb    : shared bus request (payload 0 outside BUSY)
//   i_mem_ready/rdata/error            : shared bus response
module rv32_bus_arbiter
  import rv32_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ins_valid,
  input  logic [31:0] i_ins_addr,
  output logic        o_ins_ready,
  output logic [31:0] o_ins_rdata,
  output logic        o_ins_error,
  input  logic        i_dat_valid,
  input  logic [31:0] i_dat_addr,
  input  logic        i_dat_we,
  input  logic [31:0] i_dat_wdata,
  input  logic [3:0]  i_dat_wstrb,
  output logic        o_dat_ready,
  output logic [31:0] o_dat_rdata,
  output logic        o_dat_error,
  output logic        o_mem_valid,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_error
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  state_t      state;
  grant_t      last_grant;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  logic any_req;
  logic pick_dat;
  logic expired;
  logic in_busy;
  logic ins_done;
  logic dat_done;

  assign any_req = i_ins_valid | i_dat_valid;
  // On a tie the requester not granted last wins.
  assign pick_dat = i_dat_valid && (!i_ins_valid || (last_grant == INS));

  assign in_busy = (state == BUSY);

  rv32_bus_watchdog u_watchdog (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (!in_busy),
    .i_enable  (in_busy && !i_mem_ready),
    .i_limit   (LIMIT),
    .o_expired (expired)
  );

  // last_grant doubles as the owner of the access in flight, since it is
  // updated on every grant.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      last_grant <= INS;
      req_addr   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
      req_wstrb  <= '0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= BUSY;
            last_grant <= pick_dat ? DAT : INS;
            req_addr   <= pick_dat ? i_dat_addr : i_ins_addr;
            req_we     <= pick_dat & i_dat_we;
            req_wdata  <= pick_dat ? i_dat_wdata : '0;
            req_wstrb  <= pick_dat ? i_dat_wstrb : '0;
          end
        end
        BUSY: begin
          // A slave answer on the expiry cycle still counts.
          if (i_mem_ready) begin
            state     <= RESP;
            rsp_rdata <= i_mem_rdata;
            rsp_error <= i_mem_error;
          end else if (expired) begin
            state     <= RESP;
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign o_mem_valid = in_busy;
  assign o_mem_addr  = in_busy ? req_addr  : '0;
  assign o_mem_we    = in_busy & req_we;
  assign o_mem_wdata = in_busy ? req_wdata : '0;
  assign o_mem_wstrb = in_busy ? req_wstrb : '0;

  assign ins_done = (state == RESP) && (last_grant == INS);
  assign dat_done = (state == RESP) && (last_grant == DAT);

  assign o_ins_ready = ins_done;
  assign o_ins_rdata = ins_done ? rsp_rdata : '0;
  assign o_ins_error = ins_done & rsp_error;
  assign o_dat_ready = dat_done;
  assign o_dat_rdata = dat_done ? rsp_rdata : '0;
  assign o_dat_error = dat_done & rsp_error;

endmodule

// File: doc/rv32_bus_arbiter.md
RV32_BUS_ARBITER -- requirements
Module: rv32_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning maximum BUSY cycles before the arbiter abandons a memory access (range 1..65535).
REQ-002 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports i_ins_valid input 1 and i_ins_addr input 32: instruction-fetch request and word address.
REQ-005 SHALL have ports o_ins_ready output 1, o_ins_rdata output 32 and o_ins_error output 1: fetch completion pulse, fetched word, access fault.
REQ-006 SHALL have ports i_dat_valid input 1, i_dat_addr input 32, i_dat_we input 1, i_dat_wdata input 32 and i_dat_wstrb input 4: load/store request.
REQ-007 SHALL have ports o_dat_ready output 1, o_dat_rdata output 32 and o_dat_error output 1: load/store completion pulse, load data, access fault.
REQ-008 SHALL have ports o_mem_valid, o_mem_addr[32], o_mem_we, o_mem_wdata[32] and o_mem_wstrb[4], all outputs: shared memory/peripheral request.
REQ-009 SHALL have ports i_mem_ready input 1, i_mem_rdata input 32 and i_mem_error input 1: shared bus response, sampled only while o_mem_valid=1.

Function
REQ-010 SHALL implement states IDLE, BUSY and RESP.
REQ-011 IDLE: if any i_*_valid=1, SHALL latch the winner's address, we, wdata and wstrb (ins: we=0, wstrb=0) and go to BUSY; otherwise SHALL stay in IDLE.
REQ-012 Arbitration when only one request is valid: that requester SHALL win.
REQ-013 Arbitration when both requests are valid: the requester not granted last SHALL win (round-robin); last_grant SHALL update on every grant.
REQ-014 BUSY: o_mem_valid=1 with the latched payload held stable; on i_mem_ready=1, SHALL register i_mem_rdata and i_mem_error and go to RESP.
REQ-015 BUSY: the timeout counter SHALL clear on entry and increment on each BUSY cycle without i_mem_ready.
REQ-016 When the timeout counter reaches TIMEOUT_CYCLES with i_mem_ready=0, SHALL go to RESP with error=1, rdata=0; o_mem_valid SHALL be 0 from the next cycle.
REQ-017 i_mem_ready and timeout in the same cycle: ready SHALL take precedence, with slave data/error used.
REQ-018 RESP: SHALL pulse the granted requester's o_*_ready for exactly one cycle with its rdata/error valid; the other requester's ready SHALL stay 0; next state IDLE.
REQ-019 o_*_rdata and o_*_error SHALL be 0 whenever the corresponding o_*_ready=0.
REQ-020 Minimum latency SHALL be: request cycle 0, o_mem_valid cycle 1, i_mem_ready cycle 1, o_*_ready cycle 2; the next grant SHALL be no earlier than cycle 3.
REQ-021 Requesters SHALL hold valid and payload until ready; the arbiter samples the payload only in IDLE, and valid seen in the RESP cycle SHALL be ignored.
REQ-022 o_mem_valid SHALL be 1 only in BUSY; o_mem_* payload SHALL be 0 outside BUSY.

Reset
REQ-023 i_rst=1 SHALL force IDLE, last_grant=INS (first tie goes to DAT), counter=0, and all outputs to 0 at the next edge, including mid-BUSY and mid-RESP; an abandoned access SHALL produce no ready pulse.
REQ-024 The first edge with i_rst=0 SHALL behave as IDLE with the inputs present.

Structure
REQ-025 Package rv32_bus_pkg SHALL hold the state enum (IDLE/BUSY/RESP), the grant enum (INS/DAT) and the TIMEOUT_CYCLES default constant.
REQ-026 The timeout counter SHALL be the sub-module rv32_bus_watchdog (clear, enable, limit, expired outputs); everything else SHALL be inline.

Verification
REQ-027 Load: dat valid, addr 0x0000_1000, slave ready after 2 cycles with rdata 0xDEAD_BEEF -> o_mem_addr 0x1000 for 3 cycles; o_dat_ready pulses once with 0xDEAD_BEEF, error 0.
REQ-028 Tie after reset: ins addr 0x0, dat addr 0x100, both valid, zero-wait slave -> DAT served first, then INS; a third tie serves DAT, confirming alternation.
REQ-029 Store: dat we=1, wdata 0x1234_5678, wstrb 4'b0011 -> o_mem payload matches throughout BUSY; o_dat_rdata 0, o_ins_ready never 1.
REQ-030 Timeout: TIMEOUT_CYCLES=4, slave never ready -> o_mem_valid high for exactly 5 cycles; o_ins_ready with error=1, rdata=0.
REQ-031 Collision: i_mem_ready arrives on the expiry cycle with i_mem_error=0 -> error=0 with slave rdata.
REQ-032 Mid-operation reset: i_rst pulsed during BUSY -> all outputs 0 next cycle, no ready pulse; after release, a tie goes to DAT.
